// File: rtl/elevator_pkg.sv
// Shared elevator subsystem definitions: floor and status encodings, scheduler
// state enum and default parameter values.
package elevator_pkg;

  localparam int unsigned DEF_NUM_FLOORS     = 3;
  localparam int unsigned DEF_FLOOR_W        = 2;
  localparam int unsigned DEF_DOOR_CYCLES    = 4;
  localparam int unsigned DEF_TRAVEL_TIMEOUT = 64;

  typedef enum logic [1:0] {
    FLOOR_0 = 2'd0,
    FLOOR_1 = 2'd1,
    FLOOR_2 = 2'd2
  } floor_e;

  typedef enum logic [1:0] {
    EL_IDLE = 2'b00,
    EL_UP   = 2'b01,
    EL_DOWN = 2'b10
  } elev_status_e;

  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_TRAVEL = 2'd1,
    SCHED_DOOR   = 2'd2
  } sched_state_e;

endpackage

// File: rtl/elevator_call_scheduler_if.sv
// Call-scheduler bundle: button calls and FSM feedback in, floor request and
// scheduler status out.
interface elevator_call_scheduler_if
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W    = DEF_FLOOR_W
);

  logic [NUM_FLOORS-1:0] call_req;
  logic [FLOOR_W-1:0]    current_floor;
  logic [1:0]            elevator_status;
  logic [FLOOR_W-1:0]    request_floor;
  logic [NUM_FLOORS-1:0] pending;
  logic                  door_open;
  logic                  served;
  logic [FLOOR_W-1:0]    served_floor;
  logic                  dir_up;
  logic                  fault;

  modport master (
    output call_req, current_floor, elevator_status,
    input  request_floor, pending, door_open, served, served_floor, dir_up, fault
  );

  modport slave (
    input  call_req, current_floor, elevator_status,
    output request_floor, pending, door_open, served, served_floor, dir_up, fault
  );

endinterface

// File: rtl/elevator_target_select.sv
// SCAN target picker: nearest pending floor strictly ahead in the current
// direction, otherwise the nearest one behind with the direction flipped.
module elevator_target_select
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  input  logic                  dir_up,
  output logic [FLOOR_W-1:0]    target,
  output logic                  found,
  output logic                  new_dir_up
);

  logic [FLOOR_W-1:0] up_floor;
  logic [FLOOR_W-1:0] down_floor;
  logic               up_found;
  logic               down_found;
  logic               cur_valid;

  assign cur_valid = {1'b0, current_floor} < (FLOOR_W+1)'(NUM_FLOORS);

  // Scan orders make the last hit the nearest one on each side.
  always_comb begin
    up_floor   = '0;
    up_found   = 1'b0;
    down_floor = '0;
    down_found = 1'b0;
    for (int f = int'(NUM_FLOORS) - 1; f >= 0; f--) begin
      if (pending[f] && (FLOOR_W'(f) > current_floor)) begin
        up_floor = FLOOR_W'(f);
        up_found = 1'b1;
      end
    end
    for (int f = 0; f < int'(NUM_FLOORS); f++) begin
      if (pending[f] && (FLOOR_W'(f) < current_floor)) begin
        down_floor = FLOOR_W'(f);
        down_found = 1'b1;
      end
    end
  end

  always_comb begin
    target     = '0;
    found      = 1'b0;
    new_dir_up = dir_up;
    if (cur_valid) begin
      if (dir_up) begin
        if (up_found) begin
          target = up_floor;
          found  = 1'b1;
        end else if (down_found) begin
          target     = down_floor;
          found      = 1'b1;
          new_dir_up = 1'b0;
        end
      end else begin
        if (down_found) begin
          target = down_floor;
          found  = 1'b1;
        end else if (up_found) begin
          target     = up_floor;
          found      = 1'b1;
          new_dir_up = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls and feeds the elevator FSM one SCAN target at a time,
// with door dwell timing and a sticky travel-timeout fault.
module elevator_call_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS     = DEF_NUM_FLOORS,
  parameter int unsigned FLOOR_W        = DEF_FLOOR_W,
  parameter int unsigned DOOR_CYCLES    = DEF_DOOR_CYCLES,
  parameter int unsigned TRAVEL_TIMEOUT = DEF_TRAVEL_TIMEOUT
) (
  input logic                      clk,
  input logic                      rst_n,
  elevator_call_scheduler_if.slave bus
);

  localparam int unsigned DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam int unsigned TRAVEL_W = (TRAVEL_TIMEOUT > 1) ? $clog2(TRAVEL_TIMEOUT) : 1;

  sched_state_e          state, state_nxt;
  logic [NUM_FLOORS-1:0] pending, pending_nxt;
  logic                  door_open, door_open_nxt;
  logic                  served, served_nxt;
  logic [FLOOR_W-1:0]    served_floor, served_floor_nxt;
  logic                  dir_up, dir_up_nxt;
  logic                  fault, fault_nxt;
  logic [FLOOR_W-1:0]    target, target_nxt;
  logic [DOOR_W-1:0]     door_cnt, door_cnt_nxt;
  logic [TRAVEL_W-1:0]   travel_cnt, travel_cnt_nxt;

  logic [FLOOR_W-1:0]    sel_target;
  logic                  sel_found;
  logic                  sel_dir_up;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic [NUM_FLOORS-1:0] clear_mask;
  logic [NUM_FLOORS-1:0] absorb_mask;
  logic                  here_pending;
  logic                  arrived;
  logic                  door_done;
  logic                  timed_out;
  logic [FLOOR_W-1:0]    request_floor_c;

  elevator_target_select #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_target_select (
    .pending       (pending),
    .current_floor (bus.current_floor),
    .dir_up        (dir_up),
    .target        (sel_target),
    .found         (sel_found),
    .new_dir_up    (sel_dir_up)
  );

  // One-hot of the current floor; out-of-range encodings give all zeros.
  always_comb begin
    cur_mask = '0;
    for (int f = 0; f < int'(NUM_FLOORS); f++) begin
      if (bus.current_floor == FLOOR_W'(f)) cur_mask[f] = 1'b1;
    end
  end

  assign here_pending = |(pending & cur_mask);
  assign arrived      = (bus.current_floor == target) && (bus.elevator_status == EL_IDLE);
  assign door_done    = door_cnt == DOOR_W'(DOOR_CYCLES - 1);
  assign timed_out    = travel_cnt == TRAVEL_W'(TRAVEL_TIMEOUT - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= SCHED_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCHED_IDLE: begin
        if (!fault) begin
          if (here_pending)   state_nxt = SCHED_DOOR;
          else if (sel_found) state_nxt = SCHED_TRAVEL;
        end
      end
      SCHED_TRAVEL: begin
        if (arrived)        state_nxt = SCHED_DOOR;
        else if (timed_out) state_nxt = SCHED_IDLE;
      end
      SCHED_DOOR: begin
        if (door_done) state_nxt = SCHED_IDLE;
      end
      default: state_nxt = SCHED_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters, plus the floor request mux.
  always_comb begin
    door_open_nxt    = door_open;
    served_nxt       = 1'b0;
    served_floor_nxt = served_floor;
    dir_up_nxt       = dir_up;
    fault_nxt        = fault;
    target_nxt       = target;
    door_cnt_nxt     = door_cnt;
    travel_cnt_nxt   = travel_cnt;
    clear_mask       = '0;
    absorb_mask      = '0;
    case (state)
      SCHED_IDLE: begin
        if (!fault) begin
          if (here_pending) begin
            door_open_nxt    = 1'b1;
            served_nxt       = 1'b1;
            served_floor_nxt = bus.current_floor;
            clear_mask       = cur_mask;
            door_cnt_nxt     = '0;
          end else if (sel_found) begin
            target_nxt     = sel_target;
            dir_up_nxt     = sel_dir_up;
            travel_cnt_nxt = '0;
          end
        end
      end
      SCHED_TRAVEL: begin
        if (arrived) begin
          door_open_nxt    = 1'b1;
          served_nxt       = 1'b1;
          served_floor_nxt = target;
          clear_mask       = cur_mask;
          door_cnt_nxt     = '0;
        end else if (timed_out) begin
          fault_nxt = 1'b1;
        end else begin
          travel_cnt_nxt = travel_cnt + TRAVEL_W'(1);
        end
      end
      SCHED_DOOR: begin
        absorb_mask = cur_mask;
        if (door_done) door_open_nxt = 1'b0;
        else           door_cnt_nxt  = door_cnt + DOOR_W'(1);
      end
      default: ;
    endcase
    pending_nxt     = (pending | (bus.call_req & ~absorb_mask)) & ~clear_mask;
    request_floor_c = (state == SCHED_TRAVEL) ? target : bus.current_floor;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending      <= '0;
      door_open    <= 1'b0;
      served       <= 1'b0;
      served_floor <= '0;
      dir_up       <= 1'b1;
      fault        <= 1'b0;
      target       <= '0;
      door_cnt     <= '0;
      travel_cnt   <= '0;
    end else begin
      pending      <= pending_nxt;
      door_open    <= door_open_nxt;
      served       <= served_nxt;
      served_floor <= served_floor_nxt;
      dir_up       <= dir_up_nxt;
      fault        <= fault_nxt;
      target       <= target_nxt;
      door_cnt     <= door_cnt_nxt;
      travel_cnt   <= travel_cnt_nxt;
    end
  end

  assign bus.request_floor = request_floor_c;
  assign bus.pending       = pending;
  assign bus.door_open     = door_open;
  assign bus.served        = served;
  assign bus.served_floor  = served_floor;
  assign bus.dir_up        = dir_up;
  assign bus.fault         = fault;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for elevator_call_scheduler: a dispatch table from reset plus
// hand-written arrival, door, timeout and reset sequences.
module tb_elevator_call_scheduler;
  import elevator_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec  = 0;
  int   n_miss = 0;

  elevator_call_scheduler_if #(.NUM_FLOORS(3), .FLOOR_W(2)) bus ();

  elevator_call_scheduler #(
    .NUM_FLOORS     (3),
    .FLOOR_W        (2),
    .DOOR_CYCLES    (4),
    .TRAVEL_TIMEOUT (64)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] cur;
    logic [2:0] call;
    logic [1:0] req;
    logic       dir;
    logic       door;
    logic [2:0] pend;
  } vec_t;

  vec_t vecs[11];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.call_req = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // cur, call, expected request_floor, dir_up, door_open, pending (two edges after the call)
    vecs[0]  = '{2'd0, 3'b100, 2'd2, 1'b1, 1'b0, 3'b100};
    vecs[1]  = '{2'd0, 3'b010, 2'd1, 1'b1, 1'b0, 3'b010};
    vecs[2]  = '{2'd0, 3'b110, 2'd1, 1'b1, 1'b0, 3'b110};
    vecs[3]  = '{2'd2, 3'b001, 2'd0, 1'b0, 1'b0, 3'b001};
    vecs[4]  = '{2'd2, 3'b011, 2'd1, 1'b0, 1'b0, 3'b011};
    vecs[5]  = '{2'd1, 3'b101, 2'd2, 1'b1, 1'b0, 3'b101};
    vecs[6]  = '{2'd1, 3'b001, 2'd0, 1'b0, 1'b0, 3'b001};
    vecs[7]  = '{2'd1, 3'b010, 2'd1, 1'b1, 1'b1, 3'b000};
    vecs[8]  = '{2'd1, 3'b111, 2'd1, 1'b1, 1'b1, 3'b101};
    vecs[9]  = '{2'd3, 3'b001, 2'd3, 1'b1, 1'b0, 3'b001};
    vecs[10] = '{2'd0, 3'b001, 2'd0, 1'b1, 1'b1, 3'b000};

    rst_n               = 1'b0;
    bus.call_req        = '0;
    bus.current_floor   = 2'(FLOOR_1);
    bus.elevator_status = EL_IDLE;
    @(negedge clk);
    do_reset();

    chk("reset pending",       32'(bus.pending),       32'd0);
    chk("reset door_open",     32'(bus.door_open),     32'd0);
    chk("reset served",        32'(bus.served),        32'd0);
    chk("reset served_floor",  32'(bus.served_floor),  32'd0);
    chk("reset dir_up",        32'(bus.dir_up),        32'd1);
    chk("reset fault",         32'(bus.fault),         32'd0);
    chk("reset request_floor", 32'(bus.request_floor), 32'd1);

    for (int i = 0; i < 11; i++) begin
      do_reset();
      bus.current_floor   = vecs[i].cur;
      bus.elevator_status = EL_IDLE;
      bus.call_req        = vecs[i].call;
      tick();
      bus.call_req = '0;
      tick();
      chk($sformatf("vec%0d request_floor", i), 32'(bus.request_floor), 32'(vecs[i].req));
      chk($sformatf("vec%0d dir_up", i),        32'(bus.dir_up),        32'(vecs[i].dir));
      chk($sformatf("vec%0d door_open", i),     32'(bus.door_open),     32'(vecs[i].door));
      chk($sformatf("vec%0d served", i),        32'(bus.served),        32'(vecs[i].door));
      chk($sformatf("vec%0d pending", i),       32'(bus.pending),       32'(vecs[i].pend));
    end

    // Floor 0 -> 2 trip, door dwell, call absorption and re-dispatch.
    do_reset();
    bus.current_floor   = 2'd0;
    bus.elevator_status = EL_IDLE;
    bus.call_req        = 3'b100;
    tick();
    bus.call_req = '0;
    chk("trip pending latched", 32'(bus.pending), 32'b100);
    tick();
    chk("trip request", 32'(bus.request_floor), 32'd2);
    bus.elevator_status = EL_UP;
    tick();
    bus.current_floor = 2'd1;
    tick();
    chk("trip passing floor 1", 32'(bus.served), 32'd0);
    chk("trip request held", 32'(bus.request_floor), 32'd2);
    bus.current_floor   = 2'd2;
    bus.elevator_status = EL_IDLE;
    tick();
    chk("arrive served",       32'(bus.served),       32'd1);
    chk("arrive served_floor", 32'(bus.served_floor), 32'd2);
    chk("arrive door_open",    32'(bus.door_open),    32'd1);
    chk("arrive pending",      32'(bus.pending),      32'b000);
    bus.call_req = 3'b110;
    tick();
    bus.call_req = '0;
    chk("door served pulse ends", 32'(bus.served),    32'd0);
    chk("door absorbs own floor", 32'(bus.pending),   32'b010);
    chk("door open cycle 2",      32'(bus.door_open), 32'd1);
    tick();
    tick();
    chk("door open cycle 4", 32'(bus.door_open), 32'd1);
    tick();
    chk("door closed",        32'(bus.door_open),     32'd0);
    chk("idle after door",    32'(bus.request_floor), 32'd2);
    chk("pending after door", 32'(bus.pending),       32'b010);
    tick();
    chk("redispatch request", 32'(bus.request_floor), 32'd1);
    chk("redispatch dir_up",  32'(bus.dir_up),        32'd0);

    // SCAN from floor 1 with calls at 0 and 2: up first, then reverse.
    do_reset();
    bus.current_floor   = 2'd1;
    bus.elevator_status = EL_IDLE;
    bus.call_req        = 3'b101;
    tick();
    bus.call_req = '0;
    tick();
    chk("scan first target", 32'(bus.request_floor), 32'd2);
    chk("scan first dir",    32'(bus.dir_up),        32'd1);
    bus.current_floor = 2'd2;
    tick();
    chk("scan served 2",    32'(bus.served_floor), 32'd2);
    chk("scan pending left", 32'(bus.pending),     32'b001);
    tick();
    tick();
    tick();
    tick();
    chk("scan door closed", 32'(bus.door_open), 32'd0);
    tick();
    chk("scan second target", 32'(bus.request_floor), 32'd0);
    chk("scan second dir",    32'(bus.dir_up),        32'd0);

    // Reset while travelling down toward floor 0.
    bus.current_floor   = 2'd1;
    bus.elevator_status = EL_DOWN;
    tick();
    chk("travel request before reset", 32'(bus.request_floor), 32'd0);
    rst_n = 1'b0;
    tick();
    chk("midreset pending",       32'(bus.pending),       32'd0);
    chk("midreset dir_up",        32'(bus.dir_up),        32'd1);
    chk("midreset served_floor",  32'(bus.served_floor),  32'd0);
    chk("midreset door_open",     32'(bus.door_open),     32'd0);
    chk("midreset request_floor", 32'(bus.request_floor), 32'd1);
    rst_n = 1'b1;
    tick();
    chk("after reset no dispatch", 32'(bus.request_floor), 32'd1);

    // Elevator never arrives: timeout fault, calls retained, no dispatch.
    do_reset();
    bus.current_floor   = 2'd0;
    bus.elevator_status = EL_IDLE;
    bus.call_req        = 3'b100;
    tick();
    bus.call_req = '0;
    tick();
    bus.elevator_status = EL_UP;
    chk("timeout travel start", 32'(bus.request_floor), 32'd2);
    repeat (63) tick();
    chk("timeout not yet",        32'(bus.fault),         32'd0);
    chk("timeout still travel",   32'(bus.request_floor), 32'd2);
    tick();
    chk("timeout fault",          32'(bus.fault),         32'd1);
    chk("timeout idle request",   32'(bus.request_floor), 32'd0);
    chk("timeout pending kept",   32'(bus.pending),       32'b100);
    bus.elevator_status = EL_IDLE;
    bus.call_req        = 3'b011;
    tick();
    bus.call_req = '0;
    repeat (4) tick();
    chk("fault latches calls",    32'(bus.pending),       32'b111);
    chk("fault blocks dispatch",  32'(bus.request_floor), 32'd0);
    chk("fault blocks door",      32'(bus.door_open),     32'd0);
    chk("fault sticky",           32'(bus.fault),         32'd1);
    do_reset();
    chk("fault cleared by reset", 32'(bus.fault),         32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
